multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32I core.
- Fetches an instruction over a valid/request handshake and latches it into the instruction register (IR). The IR feeds the immediate generator and the rest of the datapath.
- Decodes the opcode into an immediate-format select and datapath enables, and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Sits between instruction/data memory ports and the ALU, register file and PC logic.

---
 rtl/multicycle_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle sequencer for an RV32I core. Fetches an
//               instruction over a valid/request handshake into the IR,
//               classifies the opcode and steps it through
//               FETCH/DECODE/EXEC/MEM/WB, producing the immediate-format
//               select, memory requests and register-file/PC strobes.
// Ports       : clk, rst          - core clock, async active-high reset
//               imem_req/valid/rdata - instruction fetch handshake
//               ir                - latched instruction register
//               imm_sel, alu_src_imm - immediate format / ALU operand B mux
//               branch_taken      - ALU compare result, sampled in EXEC
//               dmem_req/we/valid - data memory handshake
//               rf_we, pc_we, pc_sel - writeback strobes and next-PC select
//               illegal, state    - trap flag and debug state
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_valid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] ir,
  output logic [2:0]       imm_sel,
  output logic             alu_src_imm,
  input  logic             branch_taken,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_valid,
  output logic             rf_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             illegal,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5,
    S_RESET  = 3'd6
  } state_t;

  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OP_OP     = 7'b0110011;

  typedef struct packed {
    logic       imem_req;
    logic [2:0] imm_sel;
    logic       alu_src_imm;
    logic       dmem_req;
    logic       dmem_we;
    logic       rf_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       illegal;
  } out_t;

  function automatic logic f_legal(input logic [6:0] op);
    // Every listed opcode ends in 2'b11, so compressed encodings fall out as illegal.
    return op inside {c_OP_LUI, c_OP_AUIPC, c_OP_JAL, c_OP_JALR, c_OP_BRANCH,
                      c_OP_LOAD, c_OP_STORE, c_OP_OPIMM, c_OP_OP};
  endfunction

  function automatic logic [2:0] f_imm_sel(input logic [6:0] op);
    case (op)
      c_OP_LUI, c_OP_AUIPC:              return 3'd3;
      c_OP_JAL:                          return 3'd4;
      c_OP_BRANCH:                       return 3'd2;
      c_OP_STORE:                        return 3'd1;
      c_OP_JALR, c_OP_LOAD, c_OP_OPIMM:  return 3'd0;
      default:                           return 3'd7;
    endcase
  endfunction

  // Moore output decode; evaluated on the next-state values so that the
  // registered outputs line up with the state they describe.
  function automatic out_t f_outs(input state_t st, input logic [6:0] op, input logic tk);
    out_t o;
    o = '0;
    case (st)
      S_FETCH: o.imem_req = 1'b1;
      S_DECODE, S_EXEC, S_MEM, S_WB: begin
        o.imm_sel     = f_imm_sel(op);
        o.alu_src_imm = op inside {c_OP_LUI, c_OP_AUIPC, c_OP_JAL, c_OP_JALR,
                                   c_OP_LOAD, c_OP_STORE, c_OP_OPIMM};
        if (st == S_MEM) begin
          o.dmem_req = 1'b1;
          o.dmem_we  = (op == c_OP_STORE);
        end
        if (st == S_WB) begin
          o.pc_we = 1'b1;
          o.rf_we = !(op == c_OP_BRANCH || op == c_OP_STORE);
          if (op == c_OP_JALR)
            o.pc_sel = 2'd2;
          else if (op == c_OP_JAL || (op == c_OP_BRANCH && tk))
            o.pc_sel = 2'd1;
        end
      end
      S_TRAP:  o.illegal = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_ir;
  logic             r_taken;
  out_t             r_out;

  state_t           w_state_nx;
  logic [WIDTH-1:0] w_ir_nx;
  logic             w_taken_nx;
  logic [6:0]       w_op;

  assign w_op = r_ir[6:0];

  always_comb begin
    w_state_nx = r_state;
    w_ir_nx    = r_ir;
    w_taken_nx = r_taken;
    case (r_state)
      S_RESET:  w_state_nx = S_FETCH;
      S_FETCH: begin
        if (imem_valid) begin
          w_ir_nx    = imem_rdata;
          w_state_nx = S_DECODE;
        end
      end
      S_DECODE: w_state_nx = f_legal(w_op) ? S_EXEC : S_TRAP;
      S_EXEC: begin
        w_taken_nx = (w_op == c_OP_BRANCH) && branch_taken;
        w_state_nx = (w_op == c_OP_LOAD || w_op == c_OP_STORE) ? S_MEM : S_WB;
      end
      S_MEM:    if (dmem_valid) w_state_nx = S_WB;
      S_WB:     w_state_nx = S_FETCH;
      S_TRAP:   w_state_nx = S_TRAP;
      default:  w_state_nx = S_RESET;
    endcase
  end

  // Async reset clears the output register too, so requests drop in the
  // same cycle rst rises and any in-flight response is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RESET;
      r_ir    <= NOP_INSTR;
      r_taken <= 1'b0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ir    <= w_ir_nx;
      r_taken <= w_taken_nx;
      r_out   <= f_outs(w_state_nx, w_ir_nx[6:0], w_taken_nx);
    end
  end

  assign state       = r_state;
  assign ir          = r_ir;
  assign imem_req    = r_out.imem_req;
  assign imm_sel     = r_out.imm_sel;
  assign alu_src_imm = r_out.alu_src_imm;
  assign dmem_req    = r_out.dmem_req;
  assign dmem_we     = r_out.dmem_we;
  assign rf_we       = r_out.rf_we;
  assign pc_we       = r_out.pc_we;
  assign pc_sel      = r_out.pc_sel;
  assign illegal     = r_out.illegal;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Directed self-checking bench for multicycle_ctrl. Each cycle
//               the expected output snapshot is queued when inputs are
//               driven and compared at the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam logic [31:0] c_NOP      = 32'h0000_0013;
  localparam logic [47:0] c_FULL     = '1;
  localparam logic [47:0] c_NO_IMM   = ~48'h0000_0000_0F00;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_valid;
  logic [31:0] imem_rdata, ir;
  logic [2:0]  imm_sel, state;
  logic        alu_src_imm, branch_taken;
  logic        dmem_req, dmem_we, dmem_valid;
  logic        rf_we, pc_we, illegal;
  logic [1:0]  pc_sel;

  typedef struct {
    string       tag;
    logic [47:0] exp;
    logic [47:0] mask;
  } exp_t;

  exp_t        q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;
  logic [31:0] prev_ir;

  always #5 clk = ~clk;

  multicycle_ctrl #(.WIDTH(32), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .ir(ir), .imm_sel(imm_sel), .alu_src_imm(alu_src_imm),
    .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_valid(dmem_valid),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .illegal(illegal), .state(state)
  );

  function automatic logic [47:0] mk(input logic [31:0] i, input logic [2:0] st,
                                     input logic ireq, input logic [2:0] isel,
                                     input logic alu, input logic dreq, input logic dwe,
                                     input logic rf, input logic pcw,
                                     input logic [1:0] pcs, input logic ill);
    return {i, st, ireq, isel, alu, dreq, dwe, rf, pcw, pcs, ill, 1'b0};
  endfunction

  function automatic logic [47:0] obs();
    return {ir, state, imem_req, imm_sel, alu_src_imm, dmem_req, dmem_we,
            rf_we, pc_we, pc_sel, illegal, 1'b0};
  endfunction

  // Queue expectation for this cycle, compare at negedge, advance to posedge+1.
  task automatic check_cycle(input string tag, input logic [47:0] e, input logic [47:0] m);
    exp_t        x;
    logic [47:0] got;
    x.tag = tag; x.exp = e; x.mask = m;
    q.push_back(x);
    @(negedge clk);
    x   = q.pop_front();
    got = obs();
    n_total++;
    assert ((got & x.mask) === (x.exp & x.mask)) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (mask %h)", x.tag, got, x.exp, x.mask);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string tag, input logic [31:0] ins, input int iw,
                           input int dw, input logic tk, input logic [2:0] isel,
                           input logic alu, input logic mem, input logic we,
                           input logic rf, input logic [1:0] pcs);
    for (int i = 0; i <= iw; i++) begin
      imem_valid = (i == iw);
      imem_rdata = (i == iw) ? ins : 32'hDEAD_BEEF;
      check_cycle({tag, "/fetch"}, mk(prev_ir, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0,
                                      1'b0, 1'b0, 2'd0, 1'b0), c_FULL);
    end
    // A stray valid outside FETCH must not reload the IR.
    imem_valid = 1'b1;
    imem_rdata = ~ins;
    check_cycle({tag, "/decode"}, mk(ins, 3'd1, 1'b0, isel, alu, 1'b0, 1'b0,
                                     1'b0, 1'b0, 2'd0, 1'b0), c_FULL);
    imem_valid   = 1'b0;
    branch_taken = tk;
    check_cycle({tag, "/exec"}, mk(ins, 3'd2, 1'b0, isel, alu, 1'b0, 1'b0,
                                   1'b0, 1'b0, 2'd0, 1'b0), c_FULL);
    branch_taken = ~tk;
    if (mem) begin
      for (int j = 0; j <= dw; j++) begin
        dmem_valid = (j == dw);
        check_cycle({tag, "/mem"}, mk(ins, 3'd3, 1'b0, isel, alu, 1'b1, we,
                                      1'b0, 1'b0, 2'd0, 1'b0), c_FULL);
      end
      dmem_valid = 1'b0;
    end
    check_cycle({tag, "/wb"}, mk(ins, 3'd4, 1'b0, isel, alu, 1'b0, 1'b0,
                                 rf, 1'b1, pcs, 1'b0), c_FULL);
    branch_taken = 1'b0;
    prev_ir      = ins;
  endtask

  initial begin
    rst          = 1'b1;
    imem_valid   = 1'b0;
    imem_rdata   = '0;
    branch_taken = 1'b0;
    dmem_valid   = 1'b0;
    prev_ir      = c_NOP;

    for (int k = 0; k < 3; k++)
      check_cycle("reset_hold", mk(c_NOP, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 2'd0, 1'b0), c_FULL);
    rst = 1'b0;
    check_cycle("reset_release", mk(c_NOP, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0,
                                    1'b0, 1'b0, 2'd0, 1'b0), c_FULL);

    run_instr("addi",   32'h0050_0093, 0, 0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    run_instr("lw",     32'h0000_A103, 2, 1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0);
    run_instr("beq_t",  32'h0020_8463, 0, 0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    run_instr("beq_nt", 32'h0020_8463, 0, 0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    run_instr("sw",     32'h0011_2223, 0, 0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    run_instr("jalr",   32'h0000_80E7, 0, 0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
    run_instr("jal",    32'h0080_00EF, 1, 0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);

    // Illegal opcode: trap is absorbing and ignores both memory valids.
    imem_valid = 1'b1;
    imem_rdata = 32'h0000_007F;
    check_cycle("ill/fetch", mk(prev_ir, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 2'd0, 1'b0), c_FULL);
    imem_rdata = 32'h0000_0013;
    check_cycle("ill/decode", mk(32'h0000_007F, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 2'd0, 1'b0), c_NO_IMM);
    dmem_valid = 1'b1;
    for (int k = 0; k < 10; k++)
      check_cycle("ill/trap", mk(32'h0000_007F, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 2'd0, 1'b1), c_NO_IMM);
    imem_valid = 1'b0;
    dmem_valid = 1'b0;

    rst = 1'b1;
    check_cycle("trap_reset", mk(c_NOP, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 2'd0, 1'b0), c_FULL);
    rst     = 1'b0;
    prev_ir = c_NOP;
    check_cycle("trap_reset_rel", mk(c_NOP, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0,
                                     1'b0, 1'b0, 2'd0, 1'b0), c_FULL);

    // Store that stalls in MEM, then reset mid-cycle with a late response.
    imem_valid = 1'b1;
    imem_rdata = 32'h0011_2223;
    check_cycle("sw_rst/fetch", mk(c_NOP, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 2'd0, 1'b0), c_FULL);
    imem_valid = 1'b0;
    check_cycle("sw_rst/decode", mk(32'h0011_2223, 3'd1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0,
                                    1'b0, 1'b0, 2'd0, 1'b0), c_FULL);
    check_cycle("sw_rst/exec", mk(32'h0011_2223, 3'd2, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0,
                                  1'b0, 1'b0, 2'd0, 1'b0), c_FULL);
    check_cycle("sw_rst/mem_stall", mk(32'h0011_2223, 3'd3, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1,
                                       1'b0, 1'b0, 2'd0, 1'b0), c_FULL);
    rst        = 1'b1;
    dmem_valid = 1'b1;
    check_cycle("sw_rst/rst_in_mem", mk(c_NOP, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0,
                                        1'b0, 1'b0, 2'd0, 1'b0), c_FULL);
    rst        = 1'b0;
    dmem_valid = 1'b0;
    check_cycle("sw_rst/release", mk(c_NOP, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0,
                                     1'b0, 1'b0, 2'd0, 1'b0), c_FULL);
    check_cycle("sw_rst/refetch", mk(c_NOP, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0,
                                     1'b0, 1'b0, 2'd0, 1'b0), c_FULL);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
